pc_0: RTL and testbench

- Program counter for the CPU datapath.
- Holds the address of the current instruction and updates it every clock edge: cleared by reset, loaded from a jump target, incremented, or held.
- Its next-value selection is a chain of 2:1 mux stages built from the existing gate-level mux primitive, so it is the first sequential consumer of the mux layer.
- Sits between the CPU jump logic, which drives in and load, and instruction memory, which consumes out.

---
 rtl/hack_pkg.sv | 17 +
 rtl/register_0.sv | 24 ++
 rtl/pc_0.sv | 50 +++++
 tb/tb_pc_0.sv | 115 +++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared Hack platform definitions: word size, PC reset vector and the 1-bit
// gate-level mux primitive that the sequential blocks are built from.
package hack_pkg;

    localparam int WORD_W = 16;
    localparam logic [WORD_W-1:0] PC_RESET_VECTOR = 16'h0000;

    // PC control priority, highest first (independent strobes, no encoding):
    //   reset -> PC_RESET_VECTOR, load -> in, inc -> out + 1, otherwise hold.

    // 1-bit mux from AND/OR/NOT gates: sel = 0 picks a, sel = 1 picks b.
    // A deselected X input is masked by its AND gate and never reaches the result.
    function automatic logic mux1(input logic a, input logic b, input logic sel);
        return (a & ~sel) | (b & sel);
    endfunction

endpackage

// File: rtl/register_0.sv
// WIDTH-bit register with synchronous load enable: per-bit DFF whose D input
// is a feedback mux selecting the stored bit or the new data.
module register_0
    import hack_pkg::*;
#(
    parameter int WIDTH = WORD_W
) (
    input  logic             clk,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic dff;

        always_ff @(posedge clk) begin
            dff <= mux1(dff, d[i], en);
        end

        assign q[i] = dff;
    end

endmodule

// File: rtl/pc_0.sv
// Program counter: next value chosen by three cascaded per-bit mux stages
// (inc, then load, then reset) and captured by an always-enabled register_0.
module pc_0
    import hack_pkg::*;
#(
    parameter int               WIDTH        = WORD_W,
    parameter logic [WIDTH-1:0] RESET_VECTOR = PC_RESET_VECTOR
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_inc;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;
    logic [WIDTH-1:0] stage_c;

    // Ripple of half adders with the carry-in forced to 1; the final carry-out
    // is dropped, so the count wraps modulo 2^WIDTH.
    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_inc
        assign out_inc[i] = out[i] ^ carry[i];
        if (i < WIDTH - 1) begin : g_carry
            assign carry[i+1] = out[i] & carry[i];
        end
    end

    // Later stages override earlier ones, which yields reset > load > inc > hold.
    for (genvar i = 0; i < WIDTH; i++) begin : g_sel
        assign stage_a[i] = mux1(out[i], out_inc[i], inc);
        assign stage_b[i] = mux1(stage_a[i], in[i], load);
        assign stage_c[i] = mux1(stage_b[i], RESET_VECTOR[i], reset);
    end

    register_0 #(
        .WIDTH(WIDTH)
    ) u_reg (
        .clk(clk),
        .en (1'b1),
        .d  (stage_c),
        .q  (out)
    );

endmodule

// File: tb/tb_pc_0.sv
// Directed and randomized bench for pc_0 against an arithmetic reference model.
module tb_pc_0;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic [15:0] out;

    int tests    = 0;
    int failures = 0;
    int model_pc = 0;

    pc_0 dut (
        .clk  (clk),
        .reset(reset),
        .in   (in),
        .load (load),
        .inc  (inc),
        .out  (out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] expected);
        tests++;
        assert (out === expected)
        else begin
            failures++;
            $error("FAIL %s: out=%h expected=%h", tag, out, expected);
        end
    endtask

    // Apply one cycle of controls, let the edge happen, advance the model, compare.
    task automatic step(input logic r, input logic l, input logic i,
                        input logic [15:0] d, input string tag);
        reset = r;
        load  = l;
        inc   = i;
        in    = d;
        @(posedge clk);
        #1;
        if (r)      model_pc = 0;
        else if (l) model_pc = int'(d);
        else if (i) model_pc = (model_pc + 1) % 65536;
        check(tag, 16'(model_pc));
    endtask

    initial begin
        logic [15:0] rnd_in;
        logic        r, l, i;

        reset = 1'b0;
        load  = 1'b0;
        inc   = 1'b0;
        in    = 16'h0000;
        @(negedge clk);

        // Reset beats load and inc
        step(1, 1, 1, 16'h1234, "reset_priority");
        check("reset_value", 16'h0000);

        // Count up from zero
        for (int k = 1; k <= 5; k++) begin
            step(0, 0, 1, 16'hxxxx, "count");
            check("count_abs", 16'(k));
        end

        // Load beats inc and takes in unmodified
        step(0, 1, 1, 16'h00A0, "load_priority");
        check("load_abs", 16'h00A0);
        step(0, 0, 1, 16'h5555, "inc_after_load");
        check("inc_after_load_abs", 16'h00A1);

        // Wrap-around
        step(0, 1, 0, 16'hFFFE, "wrap_load");
        step(0, 0, 1, 16'hxxxx, "wrap_ffff");
        check("wrap_ffff_abs", 16'hFFFF);
        step(0, 0, 1, 16'hxxxx, "wrap_0000");
        check("wrap_0000_abs", 16'h0000);
        step(0, 0, 1, 16'hxxxx, "wrap_0001");

        // Hold with X on in
        step(0, 1, 0, 16'h0010, "hold_load");
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 16'hxxxx, "hold_x");
            check("hold_abs", 16'h0010);
        end

        // Reset interrupting a count
        step(0, 1, 0, 16'h0100, "mid_load");
        step(0, 0, 1, 16'hxxxx, "mid_0101");
        check("mid_0101_abs", 16'h0101);
        step(1, 0, 1, 16'hxxxx, "mid_reset");
        check("mid_reset_abs", 16'h0000);
        step(0, 0, 1, 16'hxxxx, "mid_0001");
        check("mid_0001_abs", 16'h0001);

        // Randomized control mix
        for (int k = 0; k < 300; k++) begin
            r = ($urandom_range(0, 19) == 0);
            l = ($urandom_range(0, 3) == 0);
            i = ($urandom_range(0, 1) == 1);
            rnd_in = 16'($urandom);
            if (($urandom_range(0, 7) == 0) && (rnd_in[0] == 1'b1)) rnd_in = 16'hFFFD;
            if (!l && ($urandom_range(0, 1) == 1)) rnd_in = 16'hxxxx;
            step(r, l, i, rnd_in, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
